// File: rtl/nfc_host_seq.sv
// nfc_host_seq: sequences host erase/program/read requests through a NAND page buffer and memory controller
module nfc_host_seq #(
    parameter int DataWidth     = 16,
    parameter int PageWords     = 2048,
    parameter int TimeoutCycles = 1048575
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_cmd,
    input  logic [15:0]          req_addr,
    input  logic [DataWidth-1:0] wr_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    output logic [DataWidth-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [1:0]           resp_status,
    output logic                 nfc_start,
    output logic [2:0]           nfc_cmd,
    output logic [15:0]          RWA,
    output logic                 buf_sel,
    output logic                 buf_we,
    output logic                 buf_re,
    output logic [DataWidth-1:0] buf_in,
    input  logic [DataWidth-1:0] buf_out,
    input  logic                 nfc_done,
    input  logic                 nfc_fail
);
    localparam int CW = $clog2(PageWords);
    localparam int TW = $clog2(TimeoutCycles + 1);
    localparam logic [CW:0]   RMAX  = (CW + 1)'(PageWords);
    localparam logic [CW-1:0] WLAST = CW'(PageWords - 1);
    localparam logic [TW-1:0] TLAST = TW'(TimeoutCycles - 1);
    localparam logic [2:0] IDLE = 3'd0, FILL = 3'd1, START = 3'd2, WAIT = 3'd3, DRAIN = 3'd4, RESP = 3'd5;

    logic [2:0]           state;
    logic [1:0]           cmd_q;
    logic [15:0]          addr_q;
    logic [CW-1:0]        wcnt, pcnt;
    logic [CW:0]          rcnt;
    logic [TW-1:0]        timer;
    logic                 fill_done, we_q, inf, wp, rp, pop, wr_acc;
    logic [DataWidth-1:0] in_q;
    logic [DataWidth-1:0] mem [2];
    logic [1:0]           occ, status;

    assign req_ready   = state == IDLE;
    assign wr_ready    = state == FILL && !fill_done;
    assign wr_acc      = wr_valid && wr_ready;
    assign nfc_start   = state == START;
    assign nfc_cmd     = {1'b0, cmd_q};
    assign RWA         = addr_q;
    assign buf_sel     = state == FILL || state == DRAIN;
    assign buf_we      = we_q;
    assign buf_in      = in_q;
    assign rd_valid    = occ != 2'd0;
    assign rd_data     = mem[rp];
    assign pop         = rd_valid && rd_ready;
    // a pop this cycle frees a slot, which keeps reads streaming at one word per cycle
    assign buf_re      = state == DRAIN && rcnt != RMAX &&
                         ({1'b0, occ} + {2'b0, inf} - {2'b0, pop}) < 3'd2;
    assign resp_valid  = state == RESP;
    assign resp_status = status;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= IDLE;
            cmd_q     <= '0;
            addr_q    <= '0;
            wcnt      <= '0;
            pcnt      <= '0;
            rcnt      <= '0;
            timer     <= '0;
            fill_done <= 1'b0;
            we_q      <= 1'b0;
            inf       <= 1'b0;
            wp        <= 1'b0;
            rp        <= 1'b0;
            in_q      <= '0;
            mem[0]    <= '0;
            mem[1]    <= '0;
            occ       <= '0;
            status    <= '0;
        end else begin
            we_q <= wr_acc;
            if (wr_acc) in_q <= wr_data;
            inf <= buf_re;
            if (buf_re) rcnt <= rcnt + 1'b1;
            if (inf) begin
                mem[wp] <= buf_out;
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            occ <= occ + {1'b0, inf} - {1'b0, pop};
            case (state)
                IDLE: if (req_valid) begin
                    cmd_q     <= req_cmd;
                    addr_q    <= req_addr;
                    wcnt      <= '0;
                    pcnt      <= '0;
                    rcnt      <= '0;
                    timer     <= '0;
                    fill_done <= 1'b0;
                    status    <= req_cmd == 2'd3 ? 2'd3 : 2'd0;
                    state     <= req_cmd == 2'd3 ? RESP : req_cmd == 2'd1 ? FILL : START;
                end
                FILL: begin
                    if (wr_acc) begin
                        wcnt <= wcnt + 1'b1;
                        if (wcnt == WLAST) fill_done <= 1'b1;
                    end
                    if (fill_done) state <= START;
                end
                START: state <= WAIT;
                WAIT: begin
                    if (nfc_fail) begin
                        status <= 2'd1;
                        state  <= RESP;
                    end else if (nfc_done) begin
                        status <= 2'd0;
                        state  <= cmd_q == 2'd2 ? DRAIN : RESP;
                    end else if (timer == TLAST) begin
                        status <= 2'd2;
                        state  <= RESP;
                    end else timer <= timer + 1'b1;
                end
                DRAIN: if (pop) begin
                    pcnt <= pcnt + 1'b1;
                    if (pcnt == WLAST) begin
                        status <= 2'd0;
                        state  <= RESP;
                    end
                end
                RESP: if (resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nfc_host_seq.sv
// tb_nfc_host_seq: directed scenario bench for nfc_host_seq
module tb_nfc_host_seq;
    logic        clk = 0, Reset = 1;
    logic        req_valid = 0, req_ready;
    logic [1:0]  req_cmd = 0;
    logic [15:0] req_addr = 0;
    logic [15:0] wr_data = 0;
    logic        wr_valid = 0, wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid, rd_ready = 0;
    logic        resp_valid, resp_ready = 0;
    logic [1:0]  resp_status;
    logic        nfc_start;
    logic [2:0]  nfc_cmd;
    logic [15:0] RWA;
    logic        buf_sel, buf_we, buf_re;
    logic [15:0] buf_in, buf_out = 0;
    logic        nfc_done = 0, nfc_fail = 0;
    logic [59:0] outs;

    int tests = 0, fails = 0;
    int n_start = 0, n_we = 0, n_re = 0, n_pop = 0, n_rv = 0;
    int we_idx = 0, rd_idx = 0, re_m = 0, re_b = 0, max_out = 0;
    int we_err = 0, rd_err = 0, re_err = 0, we_at_start = 0;
    logic [2:0]  last_cmd = 0;
    logic [15:0] last_rwa = 0;

    nfc_host_seq #(.DataWidth(16), .PageWords(2048), .TimeoutCycles(100)) dut (
        .clk(clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_addr(req_addr), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status),
        .nfc_start(nfc_start), .nfc_cmd(nfc_cmd), .RWA(RWA), .buf_sel(buf_sel),
        .buf_we(buf_we), .buf_re(buf_re), .buf_in(buf_in), .buf_out(buf_out),
        .nfc_done(nfc_done), .nfc_fail(nfc_fail)
    );

    assign outs = {nfc_start, nfc_cmd, RWA, buf_sel, buf_we, buf_re, buf_in, rd_data,
                   rd_valid, resp_valid, resp_status, wr_ready};

    always #5 clk = ~clk;

    // page buffer model: word at read index N is N, one cycle after buf_re
    always @(posedge clk) begin
        if (nfc_start) re_b <= 0;
        else if (buf_re) begin
            buf_out <= 16'(re_b);
            re_b    <= re_b + 1;
        end
    end

    always @(negedge clk) begin
        if (req_valid && req_ready) begin
            we_idx = 0; rd_idx = 0; re_m = 0; max_out = 0;
        end
        if (nfc_start) begin
            n_start++; last_cmd = nfc_cmd; last_rwa = RWA; we_at_start = we_idx;
        end
        if (buf_we) begin
            n_we++;
            if (buf_in !== 16'h0030 + 16'(we_idx) || !buf_sel) we_err++;
            we_idx++;
        end
        if (buf_re) begin
            n_re++; re_m++;
            if (!buf_sel) re_err++;
        end
        if (rd_valid && rd_ready) begin
            n_pop++;
            if (rd_data !== 16'(rd_idx)) rd_err++;
            rd_idx++;
        end
        if (re_m - rd_idx > max_out) max_out = re_m - rd_idx;
        if (resp_valid) n_rv++;
    end

    task automatic do_req(input logic [1:0] c, input logic [15:0] a);
        @(posedge clk); #1;
        req_valid = 1; req_cmd = c; req_addr = a;
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic wait_resp(output logic [1:0] st, output bit ok, output bit stable);
        ok = 0; stable = 0; st = 'x;
        for (int k = 0; k < 30000 && !ok; k++) begin
            if (resp_valid) ok = 1;
            else begin @(posedge clk); #1; end
        end
        if (ok) begin
            st = resp_status;
            repeat (2) @(posedge clk);
            #1;
            stable = resp_valid && resp_status === st;
            resp_ready = 1;
            @(posedge clk); #1;
            resp_ready = 0;
        end
    endtask

    task automatic done_after(input int n, input logic d, input logic f, output bit seen);
        seen = 0;
        for (int k = 0; k < 6000 && !seen; k++) begin
            if (nfc_start) seen = 1;
            else begin @(posedge clk); #1; end
        end
        if (seen) begin
            repeat (n) @(posedge clk);
            #1;
            nfc_done = d; nfc_fail = f;
            @(posedge clk); #1;
            nfc_done = 0; nfc_fail = 0;
        end
    endtask

    task automatic fill(input bit toggle, input bit stray, input int stop, output int got);
        got = 0;
        for (int c = 0; c < 20000 && got < stop; c++) begin
            wr_valid = toggle ? c[0] : 1'b1;
            wr_data  = 16'h0030 + 16'(got);
            nfc_done = stray && got == 10;
            nfc_fail = nfc_done;
            #3;
            if (wr_valid && wr_ready) got++;
            @(posedge clk); #1;
        end
        wr_valid = 0; nfc_done = 0; nfc_fail = 0;
    endtask

    task automatic test_reset;
        Reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        tests++; if (outs !== 60'h0) begin fails++; $display("FAIL reset_outputs: got %h want 0", outs); end
        @(posedge clk); #1;
        Reset = 0;
    endtask

    task automatic test_erase;
        int b_start = n_start, b_we = n_we;
        logic [1:0] st; bit ok, stable, seen;
        do_req(2'd0, 16'h0010);
        done_after(5, 1, 0, seen);
        wait_resp(st, ok, stable);
        tests++; if (!seen || !ok) begin fails++; $display("FAIL erase_handshake: start %b resp %b want 1 1", seen, ok); end
        tests++; if (n_start - b_start != 1) begin fails++; $display("FAIL erase_starts: got %0d want 1", n_start - b_start); end
        tests++; if (last_cmd !== 3'h0 || last_rwa !== 16'h0010) begin fails++; $display("FAIL erase_cmd_addr: got %h/%h want 0/0010", last_cmd, last_rwa); end
        tests++; if (st !== 2'd0 || !stable) begin fails++; $display("FAIL erase_status: got %0d stable %b want 0 1", st, stable); end
        tests++; if (n_we != b_we) begin fails++; $display("FAIL erase_no_write: got %0d want 0", n_we - b_we); end
    endtask

    task automatic test_program;
        int b_we = n_we, b_err = we_err, got;
        logic [1:0] st; bit ok, stable, seen;
        do_req(2'd1, 16'h0010);
        fill(1, 0, 2048, got);
        done_after(3, 1, 0, seen);
        wait_resp(st, ok, stable);
        tests++; if (got != 2048) begin fails++; $display("FAIL prog_accepted: got %0d want 2048", got); end
        tests++; if (n_we - b_we != 2048) begin fails++; $display("FAIL prog_buf_we: got %0d want 2048", n_we - b_we); end
        tests++; if (we_err != b_err) begin fails++; $display("FAIL prog_buf_in_order: got %0d errors want 0", we_err - b_err); end
        tests++; if (we_at_start != 2048 || last_cmd !== 3'h1 || last_rwa !== 16'h0010) begin fails++; $display("FAIL prog_start: writes %0d cmd %h addr %h want 2048 1 0010", we_at_start, last_cmd, last_rwa); end
        tests++; if (!ok || st !== 2'd0) begin fails++; $display("FAIL prog_status: got %0d ok %b want 0 1", st, ok); end
    endtask

    task automatic test_read;
        int b_pop = n_pop, b_re = n_re, b_err = rd_err, b_rerr = re_err;
        logic [1:0] st; bit ok, stable, seen;
        do_req(2'd2, 16'h0020);
        done_after(2, 1, 0, seen);
        for (int k = 0; k < 20000 && !resp_valid; k++) begin
            rd_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        rd_ready = 0;
        wait_resp(st, ok, stable);
        tests++; if (n_pop - b_pop != 2048) begin fails++; $display("FAIL read_pops: got %0d want 2048", n_pop - b_pop); end
        tests++; if (rd_err != b_err) begin fails++; $display("FAIL read_order: got %0d errors want 0", rd_err - b_err); end
        tests++; if (max_out > 2) begin fails++; $display("FAIL read_fifo_depth: got %0d want <=2", max_out); end
        tests++; if (n_re - b_re != 2048 || re_err != b_rerr) begin fails++; $display("FAIL read_buf_re: got %0d sel errors %0d want 2048 0", n_re - b_re, re_err - b_rerr); end
        tests++; if (!ok || st !== 2'd0 || last_cmd !== 3'h2) begin fails++; $display("FAIL read_status: got %0d cmd %h want 0 2", st, last_cmd); end
    endtask

    task automatic test_back_to_back;
        int b_pop = n_pop, b_err = rd_err, n;
        logic [1:0] st; bit ok, stable, seen;
        rd_ready = 1;
        do_req(2'd2, 16'h0030);
        done_after(1, 1, 0, seen);
        n = 1;
        while (!resp_valid && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        rd_ready = 0;
        wait_resp(st, ok, stable);
        tests++; if (n != 2051) begin fails++; $display("FAIL stream_cycles: got %0d want 2051", n); end
        tests++; if (n_pop - b_pop != 2048 || rd_err != b_err) begin fails++; $display("FAIL stream_data: pops %0d errors %0d want 2048 0", n_pop - b_pop, rd_err - b_err); end
    endtask

    task automatic test_fail_same_cycle;
        int b_we = n_we, got;
        logic [1:0] st; bit ok, stable, seen;
        do_req(2'd1, 16'h0040);
        fill(0, 1, 2048, got);
        done_after(2, 1, 1, seen);
        wait_resp(st, ok, stable);
        tests++; if (n_we - b_we != 2048) begin fails++; $display("FAIL fail_stray_ignored: got %0d writes want 2048", n_we - b_we); end
        tests++; if (!ok || st !== 2'd1) begin fails++; $display("FAIL fail_status: got %0d ok %b want 1 1", st, ok); end
    endtask

    task automatic test_timeout;
        int n = 0;
        logic [1:0] st; bit ok, stable;
        do_req(2'd0, 16'h0055);
        for (int k = 0; k < 1000 && !resp_valid; k++) begin
            @(posedge clk); #1;
            n++;
        end
        wait_resp(st, ok, stable);
        tests++; if (n != 101) begin fails++; $display("FAIL timeout_cycles: got %0d want 101", n); end
        tests++; if (!ok || st !== 2'd2 || !stable) begin fails++; $display("FAIL timeout_status: got %0d stable %b want 2 1", st, stable); end
    endtask

    task automatic test_bad_cmd;
        int b_start = n_start, b_we = n_we, b_re = n_re;
        logic [1:0] st; bit ok, stable;
        do_req(2'd3, 16'h0077);
        tests++; if (resp_valid !== 1'b1) begin fails++; $display("FAIL bad_cmd_direct: got %b want 1", resp_valid); end
        wait_resp(st, ok, stable);
        tests++; if (!ok || st !== 2'd3) begin fails++; $display("FAIL bad_cmd_status: got %0d want 3", st); end
        tests++; if (n_start != b_start || n_we != b_we || n_re != b_re) begin fails++; $display("FAIL bad_cmd_quiet: starts %0d writes %0d reads %0d want 0 0 0", n_start - b_start, n_we - b_we, n_re - b_re); end
    endtask

    task automatic test_reset_abort;
        int b_start = n_start, b_we = n_we, b_rv = n_rv, got;
        do_req(2'd1, 16'h0010);
        fill(0, 0, 1000, got);
        Reset = 1;
        @(posedge clk); #1;
        Reset = 0;
        @(negedge clk);
        tests++; if (req_ready !== 1'b1 || outs !== 60'h0) begin fails++; $display("FAIL abort_outputs: ready %b outs %h want 1 0", req_ready, outs); end
        repeat (20) @(posedge clk);
        #1;
        tests++; if (n_we - b_we != 1000) begin fails++; $display("FAIL abort_writes: got %0d want 1000", n_we - b_we); end
        tests++; if (n_start != b_start || n_rv != b_rv) begin fails++; $display("FAIL abort_quiet: starts %0d resp %0d want 0 0", n_start - b_start, n_rv - b_rv); end
    endtask

    initial begin
        test_reset;
        test_erase;
        test_program;
        test_read;
        test_back_to_back;
        test_fail_same_cycle;
        test_timeout;
        test_bad_cmd;
        test_reset_abort;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
